// File: rtl/ibex_data_sram_adapter_pkg.sv
// Shared types and defaults for the data-side SRAM adapter and its response pipeline.
package ibex_data_sram_adapter_pkg;

    localparam int unsigned DEFAULT_MEM_WORDS = 4096;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0010_0000;

    // One in-flight transaction; rd marks that an SRAM read was actually issued.
    typedef struct packed {
        logic valid;
        logic err;
        logic we;
        logic rd;
    } resp_stage_t;

    function automatic logic addr_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ibex_data_sram_adapter_if.sv
// Core data-side bus between the LSU (master) and the SRAM adapter (slave).
// Handshake: a request is accepted in any cycle where req && gnt; the LSU holds
// req/addr/we/be/wdata stable until granted. Each accepted request yields exactly
// one rvalid, in order; err and rdata are meaningful only while rvalid is high.
interface ibex_data_sram_adapter_if;
    logic        req;
    logic        gnt;
    logic        rvalid;
    logic        err;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, err, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, err, rdata
    );
endinterface

// File: rtl/ibex_data_resp_pipe.sv
// Fixed-depth response pipeline: one stage per cycle of SRAM read latency, no stalls.
module ibex_data_resp_pipe
    import ibex_data_sram_adapter_pkg::*;
#(
    parameter int unsigned Latency = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  resp_stage_t stage_in,
    output resp_stage_t stage_out,
    output logic        busy_o
);

    resp_stage_t stages_q [Latency];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Latency; i++) begin
                stages_q[i] <= '0;
            end
        end else begin
            stages_q[0] <= stage_in;
            for (int i = 1; i < Latency; i++) begin
                stages_q[i] <= stages_q[i-1];
            end
        end
    end

    assign stage_out = stages_q[Latency-1];

    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < Latency; i++) begin
            busy_o = busy_o | stages_q[i].valid;
        end
    end

endmodule

// File: rtl/ibex_data_sram_adapter.sv
// Terminates the core data bus on a fixed-latency single-port SRAM: grant,
// range/alignment check, SRAM drive and in-order responses.
module ibex_data_sram_adapter
    import ibex_data_sram_adapter_pkg::*;
#(
    parameter int unsigned MemWords = DEFAULT_MEM_WORDS,
    parameter logic [31:0] BaseAddr = DEFAULT_BASE_ADDR,
    parameter int unsigned Latency  = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    ibex_data_sram_adapter_if.slave      data_bus,
    input  logic                         gnt_stall_i,
    output logic                         sram_req_o,
    output logic                         sram_we_o,
    output logic [$clog2(MemWords)-1:0]  sram_addr_o,
    output logic [3:0]                   sram_wmask_o,
    output logic [31:0]                  sram_wdata_o,
    input  logic [31:0]                  sram_rdata_i,
    output logic                         busy_o
);

    localparam int unsigned AW = $clog2(MemWords);
    // 33 bits so a window covering the whole 4 GiB space still compares correctly.
    localparam logic [32:0] WindowBytes = 33'(MemWords) * 33'd4;

    logic        gnt;
    logic [31:0] offset;
    logic        in_range;
    logic        misal;
    logic        err;
    logic        sram_req;

    resp_stage_t stage_in;
    resp_stage_t stage_out;

    // Fixed latency bounds outstanding work, so back-pressure is the only grant stall.
    assign gnt = data_bus.req & ~gnt_stall_i & ~rst_i;

    // Below-base addresses wrap to huge offsets and fall out of range naturally.
    assign offset   = data_bus.addr - BaseAddr;
    assign in_range = {1'b0, offset} < WindowBytes;
    assign misal    = addr_misaligned(data_bus.addr);
    assign err      = ~in_range | misal;

    assign sram_req = gnt & ~err & (data_bus.be != 4'b0000);

    assign sram_req_o   = sram_req;
    assign sram_we_o    = data_bus.we;
    assign sram_addr_o  = offset[AW+1:2];
    assign sram_wmask_o = data_bus.we ? data_bus.be : 4'b0000;
    assign sram_wdata_o = data_bus.wdata;

    always_comb begin
        stage_in       = '0;
        stage_in.valid = gnt;
        stage_in.err   = gnt & err;
        stage_in.we    = gnt & data_bus.we;
        stage_in.rd    = sram_req & ~data_bus.we;
    end

    ibex_data_resp_pipe #(
        .Latency (Latency)
    ) u_resp_pipe (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .stage_in  (stage_in),
        .stage_out (stage_out),
        .busy_o    (busy_o)
    );

    assign data_bus.gnt    = gnt;
    assign data_bus.rvalid = stage_out.valid;
    assign data_bus.err    = stage_out.valid & stage_out.err;
    // Stores, skipped reads and errors all return zero data.
    assign data_bus.rdata  = (stage_out.valid & stage_out.rd & ~stage_out.err & ~stage_out.we)
                             ? sram_rdata_i : 32'h0;

endmodule

// File: tb/tb_ibex_data_sram_adapter.sv
// Directed bench for the data SRAM adapter at Latency=1 (u_dut1) and Latency=3 (u_dut3).
module tb_ibex_data_sram_adapter;

    logic clk = 1'b0;
    logic rst1;
    logic rst3;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    ibex_data_sram_adapter_if bus1 ();
    ibex_data_sram_adapter_if bus3 ();

    logic        stall1, stall3;
    logic        s1_req, s1_we, s3_req, s3_we;
    logic [11:0] s1_addr, s3_addr;
    logic [3:0]  s1_mask, s3_mask;
    logic [31:0] s1_wdata, s3_wdata, s1_rdata, s3_rdata;
    logic        busy1, busy3;

    ibex_data_sram_adapter #(.MemWords(4096), .BaseAddr(32'h0010_0000), .Latency(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst1), .data_bus(bus1.slave), .gnt_stall_i(stall1),
        .sram_req_o(s1_req), .sram_we_o(s1_we), .sram_addr_o(s1_addr),
        .sram_wmask_o(s1_mask), .sram_wdata_o(s1_wdata), .sram_rdata_i(s1_rdata),
        .busy_o(busy1)
    );

    ibex_data_sram_adapter #(.MemWords(4096), .BaseAddr(32'h0010_0000), .Latency(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst3), .data_bus(bus3.slave), .gnt_stall_i(stall3),
        .sram_req_o(s3_req), .sram_we_o(s3_we), .sram_addr_o(s3_addr),
        .sram_wmask_o(s3_mask), .sram_wdata_o(s3_wdata), .sram_rdata_i(s3_rdata),
        .busy_o(busy3)
    );

    // SRAM models: synchronous, masked writes, fixed read latency.
    logic [31:0] mem1 [4096];
    logic [31:0] mem3 [4096];
    logic [31:0] rp1;
    logic [31:0] rp3 [3];

    always @(posedge clk) begin
        if (s1_req && s1_we) begin
            for (int b = 0; b < 4; b++)
                if (s1_mask[b]) mem1[s1_addr][8*b +: 8] <= s1_wdata[8*b +: 8];
        end
        if (s1_req && !s1_we) rp1 <= mem1[s1_addr];
    end
    assign s1_rdata = rp1;

    always @(posedge clk) begin
        if (s3_req && s3_we) begin
            for (int b = 0; b < 4; b++)
                if (s3_mask[b]) mem3[s3_addr][8*b +: 8] <= s3_wdata[8*b +: 8];
        end
        rp3[0] <= (s3_req && !s3_we) ? mem3[s3_addr] : 32'h0;
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end
    assign s3_rdata = rp3[2];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Drive at the negedge, then settle combinational outputs before checking.
    task automatic drive1(input logic req, input logic [31:0] addr, input logic we,
                          input logic [3:0] be, input logic [31:0] wdata);
        @(negedge clk);
        bus1.req = req; bus1.addr = addr; bus1.we = we; bus1.be = be; bus1.wdata = wdata;
        #1;
    endtask

    task automatic drive3(input logic req, input logic [31:0] addr);
        @(negedge clk);
        bus3.req = req; bus3.addr = addr; bus3.we = 1'b0; bus3.be = 4'hF; bus3.wdata = '0;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem1[i] = 32'h0;
            mem3[i] = 32'h0;
        end
        mem1[0] = 32'h0102_0304;
        mem1[1] = 32'hAABB_CCDD;
        mem1[2] = 32'h5555_AAAA;
        mem1[4] = 32'hDEAD_BEEF;
        mem3[0] = 32'h1111_1111;
        mem3[1] = 32'h2222_2222;
        mem3[2] = 32'hCAFE_F00D;
        rp1 = '0;
        rp3[0] = '0; rp3[1] = '0; rp3[2] = '0;

        rst1 = 1'b1; rst3 = 1'b1; stall1 = 1'b0; stall3 = 1'b0;
        bus1.req = 1'b1; bus1.addr = 32'h0010_0010; bus1.we = 1'b0; bus1.be = 4'hF; bus1.wdata = '0;
        bus3.req = 1'b0; bus3.addr = '0; bus3.we = 1'b0; bus3.be = 4'hF; bus3.wdata = '0;

        // Reset state, including grant suppression while req is already high
        @(negedge clk); #1;
        check("rst_gnt", 32'(bus1.gnt), 0);
        check("rst_sram_req", 32'(s1_req), 0);
        check("rst_rvalid", 32'(bus1.rvalid), 0);
        check("rst_err", 32'(bus1.err), 0);
        check("rst_rdata", bus1.rdata, 0);
        check("rst_busy", 32'(busy1), 0);
        check("rst_busy3", 32'(busy3), 0);
        rst1 = 1'b0; rst3 = 1'b0;
        bus1.req = 1'b0;

        // 1: load word 4
        drive1(1'b1, 32'h0010_0010, 1'b0, 4'hF, 32'h0);
        check("t1_gnt", 32'(bus1.gnt), 1);
        check("t1_sram_req", 32'(s1_req), 1);
        check("t1_sram_addr", 32'(s1_addr), 4);
        check("t1_rvalid_early", 32'(bus1.rvalid), 0);
        drive1(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        check("t1_rvalid", 32'(bus1.rvalid), 1);
        check("t1_err", 32'(bus1.err), 0);
        check("t1_rdata", bus1.rdata, 32'hDEAD_BEEF);

        // 2: partial store to word 1
        drive1(1'b1, 32'h0010_0004, 1'b1, 4'b0110, 32'h1122_3344);
        check("t2_gnt", 32'(bus1.gnt), 1);
        check("t2_sram_we", 32'(s1_we), 1);
        check("t2_wmask", 32'(s1_mask), 32'h6);
        check("t2_wdata", s1_wdata, 32'h1122_3344);
        check("t2_busy_idle", 32'(busy1), 0);
        drive1(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        check("t2_rvalid", 32'(bus1.rvalid), 1);
        check("t2_err", 32'(bus1.err), 0);
        check("t2_rdata", bus1.rdata, 0);
        check("t2_busy", 32'(busy1), 1);
        check("t2_mem", mem1[1], 32'hAA22_33DD);

        // 3: back-to-back split loads
        drive1(1'b1, 32'h0010_0000, 1'b0, 4'hF, 32'h0);
        check("t3_gnt_a", 32'(bus1.gnt), 1);
        drive1(1'b1, 32'h0010_0004, 1'b0, 4'hF, 32'h0);
        check("t3_gnt_b", 32'(bus1.gnt), 1);
        check("t3_sram_addr_b", 32'(s1_addr), 1);
        check("t3_rvalid_a", 32'(bus1.rvalid), 1);
        check("t3_rdata_a", bus1.rdata, 32'h0102_0304);
        drive1(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        check("t3_rvalid_b", 32'(bus1.rvalid), 1);
        check("t3_rdata_b", bus1.rdata, 32'hAA22_33DD);
        drive1(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        check("t3_idle", 32'(bus1.rvalid), 0);

        // 4: out-of-range below base, one past end, and misaligned
        drive1(1'b1, 32'h0000_0000, 1'b0, 4'hF, 32'h0);
        check("t4_lo_gnt", 32'(bus1.gnt), 1);
        check("t4_lo_sram_req", 32'(s1_req), 0);
        drive1(1'b1, 32'h0010_4000, 1'b0, 4'hF, 32'h0);
        check("t4_hi_sram_req", 32'(s1_req), 0);
        check("t4_lo_err", 32'(bus1.err), 1);
        check("t4_lo_rdata", bus1.rdata, 0);
        drive1(1'b1, 32'h0010_3FFC, 1'b0, 4'hF, 32'h0);
        check("t4_last_sram_req", 32'(s1_req), 1);
        check("t4_hi_rvalid", 32'(bus1.rvalid), 1);
        check("t4_hi_err", 32'(bus1.err), 1);
        drive1(1'b1, 32'h0010_0002, 1'b0, 4'hF, 32'h0);
        check("t4_mis_sram_req", 32'(s1_req), 0);
        check("t4_last_err", 32'(bus1.err), 0);
        drive1(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        check("t4_mis_err", 32'(bus1.err), 1);
        check("t4_mis_rdata", bus1.rdata, 0);

        // Store with no byte enables: no SRAM access, clean response
        drive1(1'b1, 32'h0010_0008, 1'b1, 4'h0, 32'hFFFF_FFFF);
        check("be0_gnt", 32'(bus1.gnt), 1);
        check("be0_sram_req", 32'(s1_req), 0);
        drive1(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        check("be0_rvalid", 32'(bus1.rvalid), 1);
        check("be0_err", 32'(bus1.err), 0);
        check("be0_mem", mem1[2], 32'h5555_AAAA);

        // 5: external stall for three cycles
        stall1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive1(1'b1, 32'h0010_0010, 1'b0, 4'hF, 32'h0);
            check("t5_stall_gnt", 32'(bus1.gnt), 0);
            check("t5_stall_sram", 32'(s1_req), 0);
            if (i > 0) check("t5_stall_rvalid", 32'(bus1.rvalid), 0);
        end
        @(negedge clk);
        stall1 = 1'b0;
        #1;
        check("t5_gnt", 32'(bus1.gnt), 1);
        drive1(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        check("t5_rvalid", 32'(bus1.rvalid), 1);
        check("t5_rdata", bus1.rdata, 32'hDEAD_BEEF);

        // 6: Latency=3, reset with three loads in flight
        drive3(1'b1, 32'h0010_0000);
        check("t6_gnt0", 32'(bus3.gnt), 1);
        drive3(1'b1, 32'h0010_0004);
        check("t6_busy", 32'(busy3), 1);
        drive3(1'b1, 32'h0010_0008);
        check("t6_gnt2", 32'(bus3.gnt), 1);
        check("t6_rvalid_early", 32'(bus3.rvalid), 0);
        @(negedge clk);
        bus3.req = 1'b0;
        rst3 = 1'b1;
        #1;
        check("t6_rst_busy", 32'(busy3), 0);
        check("t6_rst_rvalid", 32'(bus3.rvalid), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            check("t6_rst_hold_rvalid", 32'(bus3.rvalid), 0);
        end
        @(negedge clk);
        rst3 = 1'b0;
        drive3(1'b1, 32'h0010_0008);
        check("t6_new_gnt", 32'(bus3.gnt), 1);
        drive3(1'b0, 32'h0);
        check("t6_new_lat1", 32'(bus3.rvalid), 0);
        drive3(1'b0, 32'h0);
        check("t6_new_lat2", 32'(bus3.rvalid), 0);
        drive3(1'b0, 32'h0);
        check("t6_new_rvalid", 32'(bus3.rvalid), 1);
        check("t6_new_err", 32'(bus3.err), 0);
        check("t6_new_rdata", bus3.rdata, 32'hCAFE_F00D);
        drive3(1'b0, 32'h0);
        check("t6_new_done", 32'(busy3), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ibex_data_sram_adapter.md
Name: ibex_data_sram_adapter

Overview:
Downstream neighbour of the load/store unit. Terminates the core's data-side req/gnt/rvalid bus on a single-port synchronous SRAM with a fixed read latency. Generates grants, range and alignment errors, and an in-order response pipeline. Supports the back-to-back requests the LSU issues for split misaligned accesses, with up to Latency transactions outstanding.

Parameters:
MemWords, 4096, SRAM depth in 32-bit words; must be a power of two; AW = clog2(MemWords).
BaseAddr, 32'h0010_0000, byte base address of the SRAM window; aligned to MemWords*4.
Latency, 1, SRAM read latency in cycles (legal 1..3); also the fixed req-to-rvalid latency.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
data_req_i  in  1  request from LSU
data_gnt_o  out  1  grant; request accepted this cycle
data_rvalid_o  out  1  response valid (loads and stores)
data_err_o  out  1  response error, qualified by data_rvalid_o
data_addr_i  in  32  word-aligned byte address
data_we_i  in  1  1 = store
data_be_i  in  4  byte enables
data_wdata_i  in  32  store data, already lane-rotated by LSU
data_rdata_o  out  32  load data, qualified by rvalid
gnt_stall_i  in  1  external back-pressure (arbiter or bench); suppresses grant
sram_req_o  out  1  SRAM access strobe
sram_we_o  out  1  SRAM write
sram_addr_o  out  AW  SRAM word address
sram_wmask_o  out  4  SRAM byte write mask
sram_wdata_o  out  32  SRAM write data
sram_rdata_i  in  32  SRAM read data, valid Latency cycles after read strobe
busy_o  out  1  any transaction in flight

Behaviour:
- Reset values: data_gnt_o=0, data_rvalid_o=0, data_err_o=0, data_rdata_o=0, sram_req_o=0, busy_o=0. The response pipeline is cleared.
- Grant is combinational: data_gnt_o = data_req_i & ~gnt_stall_i & ~rst_i. There is no other stall source, because fixed latency bounds outstanding transactions to Latency.
- Address check on the granted cycle:
  - in_range = (data_addr_i - BaseAddr) < MemWords*4, computed as an unsigned 32-bit subtract.
  - misal = data_addr_i[1:0] != 0.
  - err = ~in_range | misal.
- SRAM strobe: sram_req_o = gnt & ~err & (data_be_i != 0).
  - sram_we_o = data_we_i.
  - sram_addr_o = (data_addr_i - BaseAddr)[AW+1:2].
  - sram_wmask_o = data_be_i when we, else 0.
  - sram_wdata_o passes data_wdata_i through.
  - A store with be=0 makes no SRAM access and responds without error.
- Response pipeline: Latency-deep shift register of {valid, err, we, rd}, where rd = sram read issued. Stage 0 loads on grant; entries shift every cycle with no stalls.
- data_rvalid_o and data_err_o come from the last stage. Every grant yields exactly one rvalid exactly Latency cycles later, in order.
- data_rdata_o = sram_rdata_i when last stage valid & rd & ~err; otherwise 32'h0.
  - Error responses and store responses return 0.
- Simultaneous events: a grant and a response in the same cycle are legal and independent. Throughput is one transaction per cycle.
- busy_o = OR of all stage valid bits.
- gnt_stall_i may toggle any cycle. The LSU holds req and address while ungranted, so the block keeps no request state.
- Reset mid-operation: in-flight responses are dropped. An SRAM write strobed before reset is committed.
- Address arithmetic wraps mod 2^32. Addresses below BaseAddr wrap to large values and are flagged out of range.

Decomposition:
- Shared package holds the response-stage struct {valid, err, we, rd} and the default BaseAddr/MemWords constants.
- One sub-module: ibex_data_resp_pipe, a Latency-parameterised shift register of the stage struct with async active-high clear.
- The top holds grant, address check and SRAM drive logic.

Test Plan:
1. Latency=1: load at 0x0010_0010, SRAM word 4 = 0xDEADBEEF.
   -> gnt same cycle; sram_addr=4; rvalid next cycle, rdata=0xDEADBEEF, err=0.
2. Store to 0x0010_0004, be=4'b0110, wdata=0x11223344.
   -> sram_we=1, wmask=0110; rvalid +1 cycle, err=0, rdata=0; word 1 updates bytes 1-2 only.
3. Back-to-back split access: loads to 0x0010_0000 then 0x0010_0004 on consecutive cycles.
   -> two grants, two rvalids on consecutive cycles, in order, with correct data.
4. Load at 0x0000_0000 (below base) and at 0x0010_4000 (one past end, MemWords=4096).
   -> gnt, sram_req=0, rvalid +Latency with err=1, rdata=0.
5. gnt_stall_i held high 3 cycles with req high.
   -> gnt=0 for those 3 cycles and no SRAM strobe; grant on the cycle stall drops.
6. Latency=3: issue 3 loads back-to-back, assert rst_i on the cycle after the third grant.
   -> no rvalid ever appears; busy_o=0 immediately; a new load after reset returns correctly.
